// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared constants, types and the round-constant table for the AES-128 key schedule.
package aes_key_sched_ctrl_pkg;

    localparam int AES_NR  = 10;
    localparam int AES_KW  = 128;
    localparam int AES_EKW = (AES_NR + 1) * AES_KW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Indexed directly by the round counter; round 0 carries no rcon.
    function automatic logic [7:0] aes_rcon(input logic [3:0] r);
        case (r)
            4'd1:    aes_rcon = 8'h01;
            4'd2:    aes_rcon = 8'h02;
            4'd3:    aes_rcon = 8'h04;
            4'd4:    aes_rcon = 8'h08;
            4'd5:    aes_rcon = 8'h10;
            4'd6:    aes_rcon = 8'h20;
            4'd7:    aes_rcon = 8'h40;
            4'd8:    aes_rcon = 8'h80;
            4'd9:    aes_rcon = 8'h1b;
            4'd10:   aes_rcon = 8'h36;
            default: aes_rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_key_round_step.sv
// One AES-128 key-expansion round (combinational) and the forward S-box it uses.
// Kept separate from the controller so the decrypt-side schedule can share it.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX_TBL[(255 - int'(a_i)) * 8 +: 8];
endmodule

module key_round_step (
    input  logic [127:0] prev,
    input  logic [7:0]   rcon,
    output logic [127:0] next
);
    logic [31:0] w0, w1, w2, w3, rot, sub, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i(rot[8*b +: 8]),
            .y_o(sub[8*b +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared round step, 11 stored round
// keys exposed as a flat bus plus a registered per-round read port.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KW-1:0]         key,
    input  logic                  key_valid,
    output logic                  key_ready,
    output logic                  busy,
    output logic                  keys_valid,
    output logic [(NR+1)*KW-1:0]  expanded_key,
    input  logic [3:0]            rk_idx,
    output logic [KW-1:0]         rk_out
);

    if (NR != 10 || KW != 128) begin : g_param_chk
        $error("aes_key_sched_ctrl supports AES-128 only (NR=10, KW=128)");
    end

    localparam logic [3:0] LAST = 4'(NR);

    ks_state_e     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [KW-1:0] slot_q [0:NR];
    logic [KW-1:0] rk_out_q;

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [KW-1:0] wr_data;
    logic [KW-1:0] step_prev, step_next;

    assign step_prev = slot_q[cnt_q - 4'd1];

    key_round_step u_step (
        .prev(step_prev),
        .rcon(aes_rcon(cnt_q)),
        .next(step_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = step_next;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    state_d = EXPAND;
                    cnt_d   = 4'd1;
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_data = key;
                end
            end
            EXPAND: begin
                // Key offers here are dropped; key_ready is low.
                wr_en = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rk_out_q <= '0;
            for (int r = 0; r <= NR; r++) slot_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wr_en) slot_q[wr_idx] <= wr_data;
            rk_out_q <= (rk_idx <= LAST) ? slot_q[rk_idx] : '0;
        end
    end

    for (genvar r = 0; r <= NR; r++) begin : g_flat
        assign expanded_key[KW*r +: KW] = slot_q[r];
    end

    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign keys_valid = (state_q == DONE);
    assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_ctrl;

    logic          clk = 1'b0;
    logic          rst, key_valid;
    logic [127:0]  key;
    logic          key_ready, busy, keys_valid;
    logic [1407:0] expanded_key;
    logic [3:0]    rk_idx;
    logic [127:0]  rk_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
        .expanded_key(expanded_key), .rk_idx(rk_idx), .rk_out(rk_out)
    );

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0]  a1_rk [11];
    logic [1407:0] a1_flat;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } rd_vec_t;
    rd_vec_t rd_vec [16];

    task automatic chk(input string name, input logic [1407:0] act, input logic [1407:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one key for a single cycle, then wait for keys_valid; returns cycles from accept.
    task automatic run_key(input logic [127:0] k, output int lat);
        key = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        lat = 1;
        while (!keys_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".key_ready"},  1408'(key_ready),  1408'(1));
        chk({tag, ".busy"},       1408'(busy),       1408'(0));
        chk({tag, ".keys_valid"}, 1408'(keys_valid), 1408'(0));
        chk({tag, ".expanded"},   expanded_key,      1408'(0));
    endtask

    initial begin
        int lat;
        int pulses;
        int last_pulse;
        a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int r = 0; r < 11; r++) a1_flat[128*r +: 128] = a1_rk[r];
        for (int i = 0; i < 16; i++) begin
            rd_vec[i].idx = 4'(i);
            rd_vec[i].exp = (i <= 10) ? a1_rk[i] : 128'h0;
        end

        rst = 1'b1; key_valid = 1'b0; key = '0; rk_idx = '0;
        tick(); tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset.rk_out", 1408'(rk_out), 1408'(0));

        // A.1 key: handshake timing cycle by cycle.
        key = KEY_A1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("a1.c%0d.key_ready", c), 1408'(key_ready), 1408'(0));
            chk($sformatf("a1.c%0d.busy", c), 1408'(busy), 1408'(1));
            chk($sformatf("a1.c%0d.keys_valid", c), 1408'(keys_valid), 1408'(0));
            tick();
        end
        chk("a1.c11.keys_valid", 1408'(keys_valid), 1408'(1));
        chk("a1.c11.busy", 1408'(busy), 1408'(0));
        chk("a1.c11.key_ready", 1408'(key_ready), 1408'(1));
        chk("a1.slot1", 1408'(expanded_key[128 +: 128]), 1408'(a1_rk[1]));
        chk("a1.slot10", 1408'(expanded_key[1280 +: 128]), 1408'(a1_rk[10]));
        chk("a1.flat", expanded_key, a1_flat);

        // Read port sweep from the vector table.
        for (int i = 0; i < 16; i++) begin
            rk_idx = rd_vec[i].idx;
            tick();
            chk($sformatf("rd.idx%0d", i), 1408'(rk_out), 1408'(rd_vec[i].exp));
        end

        // Key offered mid-expansion is ignored; re-offered in DONE it is taken.
        key = KEY_A1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick(); tick();
        key = KEY_B; key_valid = 1'b1;
        chk("ign.key_ready", 1408'(key_ready), 1408'(0));
        tick();
        key_valid = 1'b0;
        lat = 4;
        while (!keys_valid && lat < 20) begin tick(); lat++; end
        chk("ign.latency", 1408'(lat), 1408'(11));
        chk("ign.flat_a1", expanded_key, a1_flat);
        key = KEY_B; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("redo.keys_valid_drop", 1408'(keys_valid), 1408'(0));
        lat = 1;
        while (!keys_valid && lat < 20) begin tick(); lat++; end
        chk("redo.latency", 1408'(lat), 1408'(11));
        chk("redo.slot0", 1408'(expanded_key[0 +: 128]), 1408'(KEY_B));
        chk("redo.slot10", 1408'(expanded_key[1280 +: 128]), 1408'(B_RK10));

        // Reset at EXPAND cycle 5 discards the partial schedule.
        key = KEY_A1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("abort.busy_before", 1408'(busy), 1408'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        run_key(KEY_A1, lat);
        chk("abort.fresh_latency", 1408'(lat), 1408'(11));
        chk("abort.fresh_flat", expanded_key, a1_flat);

        // key_valid held high: accept on every DONE cycle, 1-cycle keys_valid pulses.
        rst = 1'b1; tick(); rst = 1'b0;
        key = KEY_A1; key_valid = 1'b1;
        pulses = 0; last_pulse = -1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (keys_valid) begin
                pulses++;
                chk($sformatf("hold.pulse%0d.cycle", pulses), 1408'(c), 1408'(11 * pulses));
                chk($sformatf("hold.pulse%0d.flat", pulses), expanded_key, a1_flat);
                last_pulse = c;
            end else if (last_pulse == c - 1 && last_pulse > 0) begin
                chk("hold.after_pulse.busy", 1408'(busy), 1408'(1));
            end
        end
        chk("hold.pulse_count", 1408'(pulses), 1408'(3));
        key_valid = 1'b0;

        // rst and key_valid together: no acceptance.
        tick();
        rst = 1'b1; key_valid = 1'b1;
        tick();
        rst = 1'b0; key_valid = 1'b0;
        chk("rstkv.key_ready", 1408'(key_ready), 1408'(1));
        chk("rstkv.busy", 1408'(busy), 1408'(0));
        tick();
        chk("rstkv.busy_next", 1408'(busy), 1408'(0));
        chk("rstkv.slot0", 1408'(expanded_key[0 +: 128]), 1408'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
